// File: rtl/vram_arbiter.sv
// ----------------------------------------------------------------------------
// vram_arbiter
//
// Arbitrates the single-port synchronous video RAM between the video fetch
// path (line buffer) and the CPU.
//
// While the beam is visible, video owns the bus in the fixed hcount phases
// selected by VIDEO_SLOT_MASK. All other cycles can serve the CPU through a
// req/ack handshake. Each CPU access takes three cycles:
//   - grant (IDLE): the CPU drives the bus.
//   - WAIT: the RAM returns read data.
//   - ACK: cpu_ack pulses.
//
// Ports
//   pixel_clock   : sole clock, all state on the rising edge
//   reset_n       : asynchronous active-low reset
//   x_phase       : hcount[2:0] from the frame controller
//   video_active  : 1 while in the visible region
//   video_addr    : fetch address from the line buffer
//   video_rdata   : RAM read data to the line buffer (straight wire)
//   cpu_req/we/addr/wdata : CPU request, held until cpu_ack
//   cpu_ack       : one-cycle completion pulse
//   cpu_rdata     : read data, valid with cpu_ack and held afterwards
//   ram_addr/we/wdata     : RAM control (combinational mux)
//   ram_rdata     : RAM read data, one cycle after the address
//   starve_max    : longest CPU wait (in cycles) observed since reset
//   wp_violation  : sticky flag for a write into the protected glyph region
//
// Optional feature: define VRAM_WRITE_PROTECT_EN to block CPU writes at
// addresses >= 16'hC000. Such writes are still granted and acked, but
// ram_we stays 0 and wp_violation is set.
// Without the macro, wp_violation is tied to 0.
// ----------------------------------------------------------------------------
module vram_arbiter #(
    parameter logic [7:0] VIDEO_SLOT_MASK = 8'b00111100,
    parameter int         ADDR_W          = 16,
    parameter int         STARVE_W        = 8
) (
    input  logic                pixel_clock,
    input  logic                reset_n,
    input  logic [2:0]          x_phase,
    input  logic                video_active,
    input  logic [ADDR_W-1:0]   video_addr,
    output logic [7:0]          video_rdata,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [7:0]          cpu_wdata,
    output logic                cpu_ack,
    output logic [7:0]          cpu_rdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_we,
    output logic [7:0]          ram_wdata,
    input  logic [7:0]          ram_rdata,
    output logic [STARVE_W-1:0] starve_max,
    output logic                wp_violation
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]          state_q,      state_d;
    logic [ADDR_W-1:0]   last_addr_q,  last_addr_d;   // last granted CPU address
    logic                is_read_q,    is_read_d;     // granted access is a read
    logic [7:0]          cpu_rdata_q,  cpu_rdata_d;
    logic [STARVE_W-1:0] wait_q,       wait_d;
    logic [STARVE_W-1:0] starve_max_q, starve_max_d;

    logic vid_own;
    logic cpu_grant;
    logic wr_blocked;   // granted write that must not reach the RAM

    // ------------------------------------------------------------------
    // Ownership and grant
    // ------------------------------------------------------------------
    always_comb begin
        vid_own   = video_active & VIDEO_SLOT_MASK[x_phase];
        // Only IDLE may grant. WAIT/ACK leave CPU slots unused.
        cpu_grant = (state_q == ST_IDLE) & cpu_req & ~vid_own;
    end

`ifdef VRAM_WRITE_PROTECT_EN
    localparam logic [ADDR_W-1:0] GLYPH_BASE = ADDR_W'(16'hC000);

    logic wp_q, wp_d;

    always_comb begin
        wr_blocked = cpu_grant & cpu_we & (cpu_addr >= GLYPH_BASE);
        wp_d       = wp_q | wr_blocked;
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            wp_q <= 1'b0;
        end else begin
            wp_q <= wp_d;
        end
    end

    assign wp_violation = wp_q;
`else
    assign wr_blocked   = 1'b0;
    assign wp_violation = 1'b0;
`endif

    // ------------------------------------------------------------------
    // RAM bus mux
    // When nobody drives the bus, the address parks on the last CPU
    // address. This keeps the RAM address stable through WAIT/ACK.
    // ------------------------------------------------------------------
    always_comb begin
        ram_addr  = last_addr_q;
        ram_we    = 1'b0;
        ram_wdata = 8'h00;
        if (vid_own) begin
            ram_addr = video_addr;
        end else if (cpu_grant) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we & ~wr_blocked;
            ram_wdata = cpu_wdata;
        end
    end

    assign video_rdata = ram_rdata;

    // ------------------------------------------------------------------
    // Access FSM, read capture and starvation tracking
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_addr_d  = last_addr_q;
        is_read_d    = is_read_q;
        cpu_rdata_d  = cpu_rdata_q;
        wait_d       = wait_q;
        starve_max_d = starve_max_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_grant) begin
                    state_d     = ST_WAIT;
                    last_addr_d = cpu_addr;
                    is_read_d   = ~cpu_we;
                    wait_d      = '0;
                    if (wait_q > starve_max_q) begin
                        starve_max_d = wait_q;
                    end
                end else if (cpu_req && vid_own && (wait_q != {STARVE_W{1'b1}})) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_WAIT: begin
                // The RAM presents data for the address issued at grant.
                if (is_read_q) begin
                    cpu_rdata_d = ram_rdata;
                end
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_addr_q  <= '0;
            is_read_q    <= 1'b0;
            cpu_rdata_q  <= 8'h00;
            wait_q       <= '0;
            starve_max_q <= '0;
        end else begin
            state_q      <= state_d;
            last_addr_q  <= last_addr_d;
            is_read_q    <= is_read_d;
            cpu_rdata_q  <= cpu_rdata_d;
            wait_q       <= wait_d;
            starve_max_q <= starve_max_d;
        end
    end

    assign cpu_ack    = (state_q == ST_ACK);
    assign cpu_rdata  = cpu_rdata_q;
    assign starve_max = starve_max_q;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

    localparam logic [7:0] MASK = 8'b00111100;

    logic        clk;
    logic        reset_n;
    logic [2:0]  x_phase;
    logic        video_active;
    logic [15:0] video_addr;
    logic [7:0]  video_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  starve_max;
    logic        wp_violation;

    vram_arbiter dut (
        .pixel_clock  (clk),
        .reset_n      (reset_n),
        .x_phase      (x_phase),
        .video_active (video_active),
        .video_addr   (video_addr),
        .video_rdata  (video_rdata),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ack      (cpu_ack),
        .cpu_rdata    (cpu_rdata),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .starve_max   (starve_max),
        .wp_violation (wp_violation)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM model. Unwritten location a holds a[7:0] ^ 8'h5A.
    logic [7:0] mem [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
        end
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected ack cycle and cpu_rdata for each issued access.
    typedef struct {
        int         ack_cyc;
        logic [7:0] rd;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (reset_n && cpu_ack) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
                chk("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, mon_e.rd});
                $display("ack: cycle %0d phase %0d rdata %h (expected cycle %0d rdata %h)",
                         cyc, x_phase, cpu_rdata, mon_e.ack_cyc, mon_e.rd);
            end
        end
    end

    // Advance one clock. Phase is a free-running hcount[2:0].
    task automatic step();
        @(posedge clk);
        #1;
        x_phase    = x_phase + 3'd1;
        video_addr = {13'h0A00, x_phase};
    endtask

    task automatic goto_phase(input logic [2:0] p);
        for (int i = 0; i < 8 && x_phase != p; i++) step();
    endtask

    // Issue one CPU access in the current cycle.
    // delay is the expected number of blocked cycles before grant.
    task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                              input int delay, input logic [7:0] exp_rd, input logic exp_we,
                              input logic keep_req);
        int  start;
        bit  got;
        exp_t e;
        start     = cyc;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        e.ack_cyc = start + delay + 2;
        e.rd      = exp_rd;
        sb_q.push_back(e);
        got = 0;
        for (int i = 0; i < 24 && !got; i++) begin
            @(negedge clk);
            if (video_active && MASK[x_phase]) begin
                chk("video_addr_out", {16'h0, ram_addr}, {16'h0, video_addr});
                chk("video_we0", {31'h0, ram_we}, 32'h0);
            end else if (cyc - start == delay) begin
                chk("grant_addr", {16'h0, ram_addr}, {16'h0, addr});
                chk("grant_we", {31'h0, ram_we}, {31'h0, exp_we});
                if (exp_we) chk("grant_wdata", {24'h0, ram_wdata}, {24'h0, wd});
            end else if (cyc - start > delay) begin
                chk("park_addr", {16'h0, ram_addr}, {16'h0, addr});
                chk("park_we0", {31'h0, ram_we}, 32'h0);
            end
            if (cpu_ack) begin
                got = 1;
                if (!keep_req) cpu_req = 1'b0;
            end else begin
                step();
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout actual=none expected=ack_at_cycle_%0d", e.ack_cyc);
            cpu_req = 1'b0;
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n      = 1'b0;
        x_phase      = 3'd0;
        video_active = 1'b0;
        video_addr   = 16'h5000;
        cpu_req      = 1'b0;
        cpu_we       = 1'b0;
        cpu_addr     = 16'h0;
        cpu_wdata    = 8'h0;
        step();
        step();
        @(negedge clk);
        chk("rst_ack", {31'h0, cpu_ack}, 32'h0);
        chk("rst_rdata", {24'h0, cpu_rdata}, 32'h0);
        chk("rst_starve", {24'h0, starve_max}, 32'h0);
        chk("rst_wp", {31'h0, wp_violation}, 32'h0);
        chk("rst_we", {31'h0, ram_we}, 32'h0);
        chk("rst_addr", {16'h0, ram_addr}, 32'h0);
        step();
        reset_n = 1'b1;
        step();

        // Idle bus: write then read back.
        goto_phase(3'd3);
        cpu_access(1'b1, 16'h8005, 8'h41, 0, 8'h00, 1'b1, 1'b0);
        cpu_access(1'b0, 16'h8005, 8'h00, 0, 8'h41, 1'b0, 1'b0);
        cpu_access(1'b0, 16'h1234, 8'h00, 0, 8'h6E, 1'b0, 1'b0);

        // Slot blocking: request at phase 2 waits through phases 2-5.
        video_active = 1'b1;
        goto_phase(3'd2);
        cpu_access(1'b0, 16'h8005, 8'h00, 4, 8'h41, 1'b0, 1'b0);
        chk("starve_max_4", {24'h0, starve_max}, 32'd4);

        // Free-slot grant at phase 0; ACK lands in a video phase.
        goto_phase(3'd0);
        cpu_access(1'b0, 16'h1234, 8'h00, 0, 8'h6E, 1'b0, 1'b0);
        chk("starve_max_keep", {24'h0, starve_max}, 32'd4);

        // Back-to-back: req held through ACK gives a second access.
        goto_phase(3'd6);
        cpu_access(1'b1, 16'h8010, 8'h22, 0, 8'h6E, 1'b1, 1'b1);
        cpu_access(1'b0, 16'h8010, 8'h00, 0, 8'h22, 1'b0, 1'b0);

        // Reset during WAIT: no ack, everything back to reset values.
        video_active = 1'b0;
        goto_phase(3'd0);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h8010;
        step();
        reset_n = 1'b0;
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_ack", {31'h0, cpu_ack}, 32'h0);
            step();
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ack", {31'h0, cpu_ack}, 32'h0);
        chk("post_rst_rdata", {24'h0, cpu_rdata}, 32'h0);
        chk("post_rst_starve", {24'h0, starve_max}, 32'h0);
        chk("post_rst_we", {31'h0, ram_we}, 32'h0);
        chk("post_rst_addr", {16'h0, ram_addr}, 32'h0);
        step();
        cpu_access(1'b0, 16'h8005, 8'h00, 0, 8'h41, 1'b0, 1'b0);

        // Glyph-region write.
`ifdef VRAM_WRITE_PROTECT_EN
        cpu_access(1'b1, 16'hC010, 8'hFF, 0, 8'h41, 1'b0, 1'b0);
        chk("wp_set", {31'h0, wp_violation}, 32'h1);
        cpu_access(1'b0, 16'hC010, 8'h00, 0, 8'h4A, 1'b0, 1'b0);
        cpu_access(1'b1, 16'h8000, 8'h33, 0, 8'h4A, 1'b1, 1'b0);
        chk("wp_sticky", {31'h0, wp_violation}, 32'h1);
`else
        cpu_access(1'b1, 16'hC010, 8'hFF, 0, 8'h41, 1'b1, 1'b0);
        chk("wp_tied0", {31'h0, wp_violation}, 32'h0);
        cpu_access(1'b0, 16'hC010, 8'h00, 0, 8'hFF, 1'b0, 1'b0);
        cpu_access(1'b1, 16'h8000, 8'h33, 0, 8'hFF, 1'b1, 1'b0);
`endif
        cpu_access(1'b0, 16'h8000, 8'h00, 0, 8'h33, 1'b0, 1'b0);

        step();
        step();
        chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port synchronous video RAM between the character/pixel fetch path and the CPU.
- Video fetch owns the RAM bus in fixed hcount-phase slots while the beam is active. The CPU gets every other cycle through a req/ack handshake.
- Sits directly upstream of the line buffer: it sources the line buffer's VRAM data and consumes its VRAM address.

Parameters:
- VIDEO_SLOT_MASK, 8'b00111100: bit p=1 means phase p (hcount[2:0]) belongs to video while video_active=1.
- ADDR_W, 16: VRAM address width.
- STARVE_W, 8: width of the saturating starvation counter.

Ports:
- pixel_clock  in  1  sole clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- x_phase  in  3  hcount[2:0] from frame controller
- video_active  in  1  1 = visible region (not hblank/vblank)
- video_addr  in  ADDR_W  fetch address from line buffer
- video_rdata  out  8  RAM read data to line buffer (wire from ram_rdata)
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data, valid while cpu_ack=1 and held after
- ram_addr  out  ADDR_W  RAM address (combinational mux)
- ram_we  out  1  RAM write enable (combinational)
- ram_wdata  out  8  RAM write data (combinational)
- ram_rdata  in  8  RAM read data, valid one cycle after address
- starve_max  out  STARVE_W  worst-case CPU wait in cycles since reset
- wp_violation  out  1  sticky flag, only with optional feature

Behaviour:
- Bus ownership:
  - vid_own = video_active & VIDEO_SLOT_MASK[x_phase].
  - vid_own=1: ram_addr=video_addr, ram_we=0, ram_wdata=0.
- FSM states: IDLE, WAIT, ACK. Reset puts the FSM in IDLE.
- IDLE:
  - cpu_grant = cpu_req & ~vid_own.
  - On grant: ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata in the same cycle. Next state is WAIT.
  - Without grant: ram_addr holds the last CPU address, ram_we=0.
- WAIT:
  - ram_we=0. RAM returns read data this cycle.
  - cpu_rdata <= ram_rdata on the clock edge at the end of the cycle, for reads only; writes leave cpu_rdata unchanged.
  - Next state is ACK.
- ACK:
  - cpu_ack=1 for exactly this cycle.
  - Next state is IDLE.
  - The CPU must drop cpu_req during ACK. A req still high in the following IDLE cycle is a new access.
- Latency: grant in cycle t, cpu_ack high in cycle t+2.
  - Reads and writes have identical timing.
  - Worst-case wait from req to grant is the longest run of 1s in the mask (4 cycles by default).
- WAIT and ACK never drive the bus. Video slots arriving during WAIT or ACK are served normally; CPU slots during WAIT/ACK go unused.
- The CPU request is not captured. cpu_addr, cpu_we and cpu_wdata are sampled only in the grant cycle and must be stable from req rise to ack.
- video_active falling mid-line: all phases immediately become CPU-eligible, starting with the same cycle.
- Starvation counter:
  - Internal wait counter clears on grant.
  - Increments, saturating at all-ones, for each IDLE cycle with cpu_req=1 and vid_own=1.
  - starve_max <= max(starve_max, wait) at grant.
- Reset values: cpu_ack=0, cpu_rdata=0, starve_max=0, wait=0, wp_violation=0, last CPU address=0, ram_we=0.
- Asserting reset_n low mid-access aborts it: no ack is issued and the FSM returns to IDLE. A write already issued in the grant cycle is not undone.

Optional Feature:
- Macro: VRAM_WRITE_PROTECT_EN.
- When defined:
  - A CPU write with cpu_addr >= 16'hC000 (glyph region) is still granted and acked normally, but ram_we stays 0.
  - wp_violation is set to 1 and stays set until reset.
  - Reads of the glyph region are unaffected.
- When not defined: all CPU writes reach RAM, and wp_violation is tied to 0.

Test Plan:
- Idle bus: video_active=0, CPU write 0x8005<=0x41 at phase 3 → ram_we=1 with ram_addr=0x8005 in the same cycle, cpu_ack 2 cycles later. A following read of 0x8005 returns cpu_rdata=0x41 with its ack.
- Slot blocking: video_active=1, cpu_req rises at phase 2 → no grant in phases 2-5, grant at phase 6, cpu_ack at phase 0, starve_max=4. During phases 2-5 ram_addr tracks video_addr.
- Free-slot grant: video_active=1, req at phase 0 → grant at phase 0, ack at phase 2. Video addresses are output on phases 2-5 with no conflict.
- Back-to-back: cpu_req held high through ACK → a second access is granted in the next free IDLE cycle, giving two cpu_ack pulses.
- Reset mid-access: reset_n low during WAIT → cpu_ack never pulses; after release all outputs are at their reset values and the FSM is in IDLE.
- VRAM_WRITE_PROTECT_EN defined: write 0xC010<=0xFF → cpu_ack=1, ram_we=0 throughout, wp_violation=1; a write to 0x8000 still asserts ram_we.
